// File: rtl/cr_clint_pkg.sv
// ---------------------------------------------------------------------------
// cr_clint_pkg : CLINT address map, privilege encoding and hart index decode
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cr_clint_pkg;

  localparam logic [31:0] MSIP_BASE  = 32'h0000_0000;
  localparam logic [31:0] MTCMP_BASE = 32'h0000_4000;
  localparam logic [31:0] MTIME_LO   = 32'h0000_BFF8;
  localparam logic [31:0] MTIME_HI   = 32'h0000_BFFC;
  localparam logic [31:0] CLRCNT     = 32'h0000_C000;
  localparam logic [1:0]  MODE_M     = 2'b11;

  // MSIP slots are 4 bytes apart and MTIMECMP slots 8 bytes apart; bit 14
  // tells the two windows apart once the caller has range-checked the address.
  function automatic logic [31:0] hart_idx(input logic [31:0] addr);
    if (addr[14]) return (addr - MTCMP_BASE) >> 3;
    else          return (addr - MSIP_BASE) >> 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cr_clint_hart_regs.sv
// ---------------------------------------------------------------------------
// cr_clint_hart_regs : per-hart msip, 64-bit mtimecmp and registered compare
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cr_clint_hart_regs #(
  parameter logic [63:0] MTIMECMP_RST = {64{1'b1}}
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        msip_we_i,
  input  logic        cmplo_we_i,
  input  logic        cmphi_we_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] mtime_i,
  output logic        msip_o,
  output logic [63:0] mtimecmp_o,
  output logic        mt_int_o
);

  logic        msip_q;
  logic [63:0] cmp_q;
  logic        mt_int_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msip_q   <= 1'b0;
      cmp_q    <= MTIMECMP_RST;
      mt_int_q <= 1'b0;
    end else begin
      if (msip_we_i)  msip_q        <= wdata_i[0];
      if (cmplo_we_i) cmp_q[31:0]   <= wdata_i;
      if (cmphi_we_i) cmp_q[63:32]  <= wdata_i;
      // Compare uses the stored value, so a raising write clears the irq one cycle later.
      mt_int_q <= (mtime_i >= cmp_q);
    end
  end

  assign msip_o     = msip_q;
  assign mtimecmp_o = cmp_q;
  assign mt_int_o   = mt_int_q;

endmodule

`default_nettype wire

// File: rtl/cr_clint_mh_top.sv
// ---------------------------------------------------------------------------
// cr_clint_mh_top : multi-hart CLINT with shared mtime and tcipif slave port.
// Optional macro CLINT_INT_MTIME_EN selects an internal, writable mtime counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cr_clint_mh_top
  import cr_clint_pkg::*;
#(
  parameter int          HART_NUM     = 4,
  parameter int          ADDR_W       = 16,
  parameter logic [63:0] MTIMECMP_RST = {64{1'b1}},
  parameter int          MTIME_DIV    = 1
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic [1:0]          cpu_clint_mode,
  input  logic                tcipif_clint_sel,
  input  logic                tcipif_clint_write,
  input  logic [ADDR_W-1:0]   tcipif_clint_addr,
  input  logic [31:0]         tcipif_clint_wdata,
  input  logic [63:0]         sysio_clint_mtime,
  input  logic [HART_NUM-1:0] sysio_clint_me_int,
  output logic                clint_tcipif_cmplt,
  output logic [31:0]         clint_tcipif_rdata,
  output logic [HART_NUM-1:0] clint_cpu_ms_int,
  output logic [HART_NUM-1:0] clint_cpu_mt_int,
  output logic [HART_NUM-1:0] clint_cpu_me_int,
  output logic                clear_cnt_to_cputop
);

  logic [31:0]         w_addr;
  logic                w_mode_m;
  logic                w_wr_ok;
  logic                w_in_msip;
  logic                w_in_cmp;
  logic [31:0]         w_idx;
  logic                w_hart_ok;
  logic [31:0]         w_rdata;
  logic [HART_NUM-1:0] w_msip;
  logic [63:0]         w_cmp [HART_NUM];

  logic                cmplt_q;
  logic [31:0]         rdata_q, rdata_d;
  logic [HART_NUM-1:0] me_int_q;
  logic                clear_q;
  logic [63:0]         mtime_q;

  generate
    if (ADDR_W < 32) begin : g_addr_ext
      assign w_addr = {{(32-ADDR_W){1'b0}}, tcipif_clint_addr};
    end else begin : g_addr_trunc
      assign w_addr = tcipif_clint_addr[31:0];
    end
  endgenerate

  assign w_mode_m  = (cpu_clint_mode == MODE_M);
  assign w_wr_ok   = tcipif_clint_sel & tcipif_clint_write & w_mode_m;
  assign w_in_msip = (w_addr[31:14] == 18'd0) && (w_addr[1:0] == 2'b00);
  assign w_in_cmp  = (w_addr[31:14] == 18'd1) && (w_addr[1:0] == 2'b00);
  assign w_idx     = hart_idx(w_addr);
  assign w_hart_ok = (w_idx < 32'(HART_NUM));

  generate
    for (genvar h = 0; h < HART_NUM; h++) begin : g_hart
      logic w_hit;
      assign w_hit = w_wr_ok && w_hart_ok && (w_idx == 32'(h));

      cr_clint_hart_regs #(
        .MTIMECMP_RST (MTIMECMP_RST)
      ) u_regs (
        .clk_i      (forever_cpuclk),
        .rst_i      (cpurst),
        .msip_we_i  (w_hit && w_in_msip),
        .cmplo_we_i (w_hit && w_in_cmp && !w_addr[2]),
        .cmphi_we_i (w_hit && w_in_cmp &&  w_addr[2]),
        .wdata_i    (tcipif_clint_wdata),
        .mtime_i    (mtime_q),
        .msip_o     (w_msip[h]),
        .mtimecmp_o (w_cmp[h]),
        .mt_int_o   (clint_cpu_mt_int[h])
      );
    end
  endgenerate

  always_comb begin
    w_rdata = 32'd0;
    if (w_hart_ok) begin
      for (int h = 0; h < HART_NUM; h++) begin
        if (w_idx == 32'(h)) begin
          if (w_in_msip)     w_rdata = {31'd0, w_msip[h]};
          else if (w_in_cmp) w_rdata = w_addr[2] ? w_cmp[h][63:32] : w_cmp[h][31:0];
        end
      end
    end
    if (w_addr == MTIME_LO) w_rdata = mtime_q[31:0];
    if (w_addr == MTIME_HI) w_rdata = mtime_q[63:32];
    rdata_d = (tcipif_clint_sel && !tcipif_clint_write && w_mode_m) ? w_rdata : 32'd0;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      cmplt_q  <= 1'b0;
      rdata_q  <= 32'd0;
      me_int_q <= '0;
      clear_q  <= 1'b0;
    end else begin
      cmplt_q  <= tcipif_clint_sel;
      rdata_q  <= rdata_d;
      me_int_q <= sysio_clint_me_int;
      clear_q  <= w_wr_ok && (w_addr == CLRCNT);
    end
  end

`ifdef CLINT_INT_MTIME_EN
  logic [7:0]  div_q, div_d;
  logic [63:0] mtime_d;
  logic        w_tick;

  assign w_tick = (div_q == 8'(MTIME_DIV - 1));

  // A half write reloads that half and restarts the divider; it beats a tick.
  always_comb begin
    mtime_d = mtime_q;
    div_d   = div_q + 8'd1;
    if (w_wr_ok && (w_addr == MTIME_LO)) begin
      mtime_d[31:0] = tcipif_clint_wdata;
      div_d         = 8'd0;
    end else if (w_wr_ok && (w_addr == MTIME_HI)) begin
      mtime_d[63:32] = tcipif_clint_wdata;
      div_d          = 8'd0;
    end else if (w_tick) begin
      mtime_d = mtime_q + 64'd1;
      div_d   = 8'd0;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      mtime_q <= 64'd0;
      div_q   <= 8'd0;
    end else begin
      mtime_q <= mtime_d;
      div_q   <= div_d;
    end
  end
`else
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) mtime_q <= 64'd0;
    else        mtime_q <= sysio_clint_mtime;
  end
`endif

  assign clint_tcipif_cmplt  = cmplt_q;
  assign clint_tcipif_rdata  = rdata_q;
  assign clint_cpu_ms_int    = w_msip;
  assign clint_cpu_me_int    = me_int_q;
  assign clear_cnt_to_cputop = clear_q;

endmodule

`default_nettype wire

// File: tb/tb_cr_clint_mh_top.sv
// ---------------------------------------------------------------------------
// tb_cr_clint_mh_top : directed self-checking bench for cr_clint_mh_top
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cr_clint_mh_top;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        sel;
  logic        wr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [63:0] mtime_in;
  logic [3:0]  me_in;
  logic        cmplt;
  logic [31:0] rdata;
  logic [3:0]  ms_int, mt_int, me_int;
  logic        clr;

  int checks = 0;
  int errors = 0;

  cr_clint_mh_top #(
    .HART_NUM     (4),
    .ADDR_W       (16),
    .MTIMECMP_RST ({64{1'b1}}),
    .MTIME_DIV    (2)
  ) dut (
    .forever_cpuclk      (clk),
    .cpurst              (rst),
    .cpu_clint_mode      (mode),
    .tcipif_clint_sel    (sel),
    .tcipif_clint_write  (wr),
    .tcipif_clint_addr   (addr),
    .tcipif_clint_wdata  (wdata),
    .sysio_clint_mtime   (mtime_in),
    .sysio_clint_me_int  (me_in),
    .clint_tcipif_cmplt  (cmplt),
    .clint_tcipif_rdata  (rdata),
    .clint_cpu_ms_int    (ms_int),
    .clint_cpu_mt_int    (mt_int),
    .clint_cpu_me_int    (me_int),
    .clear_cnt_to_cputop (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access; returns cmplt/rdata as seen in the following cycle.
  task automatic bus(input logic w, input logic [15:0] a, input logic [31:0] d,
                     input logic [1:0] m, output logic [31:0] rd, output logic c);
    sel = 1'b1; wr = w; addr = a; wdata = d; mode = m;
    tick();
    sel = 1'b0; wr = 1'b0; mode = 2'b11;
    rd = rdata; c = cmplt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 1'b1; wr = 1'b0; addr = 16'h4000; mode = 2'b11;
    tick();
    checks++;
    if (cmplt !== 1'b0) begin errors++; $display("FAIL reset_cmplt got %b exp 0", cmplt); end
    sel = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({cmplt, rdata, ms_int, mt_int, me_int, clr} !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs got cmplt=%b rdata=%h ms=%b mt=%b me=%b clr=%b exp all 0",
               cmplt, rdata, ms_int, mt_int, me_int, clr);
    end
  endtask

  task automatic test_cmp_reset_read();
    logic [31:0] rd; logic c;
    bus(1'b0, 16'h4000, 32'd0, 2'b11, rd, c);
    checks++;
    if (c !== 1'b1 || rd !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL cmplo0_reset got c=%b rd=%h exp c=1 rd=ffffffff", c, rd);
    end
    bus(1'b0, 16'h4004, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmphi0_reset got %h exp ffffffff", rd); end
  endtask

  task automatic test_msip();
    logic [31:0] rd; logic c;
    bus(1'b1, 16'h0008, 32'd1, 2'b11, rd, c);
    checks++;
    if (ms_int !== 4'b0100) begin errors++; $display("FAIL msip2_set got %b exp 0100", ms_int); end
    bus(1'b0, 16'h0008, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL msip2_read1 got %h exp 1", rd); end
    bus(1'b1, 16'h0008, 32'd0, 2'b11, rd, c);
    checks++;
    if (ms_int !== 4'b0000) begin errors++; $display("FAIL msip2_clr got %b exp 0000", ms_int); end
    bus(1'b0, 16'h0008, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL msip2_read0 got %h exp 0", rd); end
  endtask

  task automatic test_timer();
    logic [31:0] rd; logic c;
    mtime_in = 64'h100;
    tick(); tick();
    bus(1'b0, 16'hBFF8, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'h100) begin errors++; $display("FAIL mtimelo_read got %h exp 100", rd); end
    bus(1'b1, 16'h400C, 32'd0, 2'b11, rd, c);
    tick();
    checks++;
    if (mt_int !== 4'b0000) begin errors++; $display("FAIL mt_after_hi got %b exp 0000", mt_int); end
    bus(1'b1, 16'h4008, 32'h100, 2'b11, rd, c);
    tick();
    checks++;
    if (mt_int !== 4'b0010) begin errors++; $display("FAIL mt1_equal got %b exp 0010", mt_int); end
    bus(1'b1, 16'h4008, 32'h200, 2'b11, rd, c);
    tick();
    checks++;
    if (mt_int !== 4'b0000) begin errors++; $display("FAIL mt1_raised got %b exp 0000", mt_int); end
    bus(1'b1, 16'hBFF8, 32'h5555, 2'b11, rd, c);
    bus(1'b0, 16'hBFF8, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'h100) begin errors++; $display("FAIL mtime_ro got %h exp 100", rd); end
  endtask

  task automatic test_perm_unmapped();
    logic [31:0] rd; logic c;
    bus(1'b1, 16'h0000, 32'd1, 2'b00, rd, c);
    checks++;
    if (c !== 1'b1 || ms_int !== 4'b0000) begin
      errors++; $display("FAIL user_write got c=%b ms=%b exp c=1 ms=0000", c, ms_int);
    end
    bus(1'b0, 16'h4000, 32'd0, 2'b00, rd, c);
    checks++;
    if (c !== 1'b1 || rd !== 32'd0) begin
      errors++; $display("FAIL user_read got c=%b rd=%h exp c=1 rd=0", c, rd);
    end
    bus(1'b0, 16'h6000, 32'd0, 2'b11, rd, c);
    checks++;
    if (c !== 1'b1 || rd !== 32'd0) begin
      errors++; $display("FAIL unmapped_read got c=%b rd=%h exp c=1 rd=0", c, rd);
    end
    bus(1'b1, 16'h0010, 32'd1, 2'b11, rd, c);
    bus(1'b0, 16'h0010, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'd0 || ms_int !== 4'b0000) begin
      errors++; $display("FAIL hart4_oob got rd=%h ms=%b exp rd=0 ms=0000", rd, ms_int);
    end
  endtask

  task automatic test_back_to_back();
    logic        v_wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] v_ad [4] = '{16'h000C, 16'h000C, 16'h4018, 16'h4018};
    logic [31:0] v_wd [4] = '{32'd1, 32'd0, 32'h1234_5678, 32'd0};
    logic [31:0] v_ex [4] = '{32'd0, 32'd1, 32'd0, 32'h1234_5678};
    for (int i = 0; i < 4; i++) begin
      sel = 1'b1; wr = v_wr[i]; addr = v_ad[i]; wdata = v_wd[i]; mode = 2'b11;
      tick();
      checks++;
      if (cmplt !== 1'b1 || rdata !== v_ex[i]) begin
        errors++; $display("FAIL b2b_%0d got c=%b rd=%h exp c=1 rd=%h", i, cmplt, rdata, v_ex[i]);
      end
    end
    sel = 1'b0; wr = 1'b0;
    tick();
    checks++;
    if (cmplt !== 1'b0 || ms_int !== 4'b1000) begin
      errors++; $display("FAIL b2b_idle got c=%b ms=%b exp c=0 ms=1000", cmplt, ms_int);
    end
  endtask

  task automatic test_clrcnt();
    logic [31:0] rd; logic c;
    bus(1'b1, 16'hC000, 32'hDEAD_BEEF, 2'b11, rd, c);
    checks++;
    if (clr !== 1'b1) begin errors++; $display("FAIL clrcnt_pulse got %b exp 1", clr); end
    tick();
    checks++;
    if (clr !== 1'b0) begin errors++; $display("FAIL clrcnt_width got %b exp 0", clr); end
    bus(1'b1, 16'hC000, 32'd0, 2'b01, rd, c);
    checks++;
    if (clr !== 1'b0) begin errors++; $display("FAIL clrcnt_user got %b exp 0", clr); end
    bus(1'b0, 16'hC000, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'd0 || clr !== 1'b0) begin
      errors++; $display("FAIL clrcnt_read got rd=%h clr=%b exp rd=0 clr=0", rd, clr);
    end
  endtask

  task automatic test_me_int();
    me_in = 4'b1010;
    #1;
    checks++;
    if (me_int !== 4'b0000) begin errors++; $display("FAIL me_early got %b exp 0000", me_int); end
    tick();
    checks++;
    if (me_int !== 4'b1010) begin errors++; $display("FAIL me_flop got %b exp 1010", me_int); end
  endtask

`ifdef CLINT_INT_MTIME_EN
  task automatic test_mtime_counter();
    logic [31:0] rd; logic c;
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 2'b11, rd, c);
    bus(1'b1, 16'hBFFC, 32'd0, 2'b11, rd, c);
    bus(1'b0, 16'hBFF8, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mtime_lo_hold got %h exp ffffffff", rd); end
    bus(1'b0, 16'hBFFC, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL mtime_hi_pre got %h exp 0", rd); end
    bus(1'b0, 16'hBFFC, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL mtime_hi_carry got %h exp 1", rd); end
    bus(1'b0, 16'hBFF8, 32'd0, 2'b11, rd, c);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL mtime_lo_wrap got %h exp 0", rd); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 2'b11; sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    mtime_in = 64'd0; me_in = 4'd0;
    tick(); tick();
    test_reset();
    test_cmp_reset_read();
    test_msip();
`ifdef CLINT_INT_MTIME_EN
    test_mtime_counter();
`else
    test_timer();
`endif
    test_perm_unmapped();
    test_back_to_back();
    test_clrcnt();
    test_me_int();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
